// File: rtl/wbcon_tx.sv
// Serializes one Wishbone console command result into a byte stream:
// a header byte, then the read word little-endian for successful reads.
module wbcon_tx #(
  parameter int WB_DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cres_tvalid,
  output logic                     o_cres_tready,
  input  logic                     i_cres_op_null,
  input  logic                     i_cres_op_set_address,
  input  logic                     i_cres_op_write_word,
  input  logic                     i_cres_op_read_word,
  input  logic [WB_DATA_WIDTH-1:0] i_cres_hw_data,
  input  logic                     i_cres_bus_err,
  input  logic                     i_cres_bus_rty,
  output logic                     o_tx_tvalid,
  input  logic                     i_tx_tready,
  output logic [7:0]               o_tx_tdata
);

  localparam int DATA_BYTES = (WB_DATA_WIDTH + 7) / 8;
  localparam int DATA_W     = DATA_BYTES * 8;
  localparam int CNT_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic              err_q;
  logic              rty_q;
  logic [DATA_W-1:0] data_q;

  logic [1:0] op_in;
  logic       cres_fire;
  logic       tx_fire;
  logic       has_payload;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_in = 2'b00;
    if (i_cres_op_read_word)        op_in = 2'b11;
    else if (i_cres_op_write_word)  op_in = 2'b10;
    else if (i_cres_op_set_address) op_in = 2'b01;
    else if (i_cres_op_null)        op_in = 2'b00;
  end

  assign o_cres_tready = (state == S_IDLE);
  assign o_tx_tvalid   = (state != S_IDLE);
  assign cres_fire     = i_cres_tvalid && o_cres_tready;
  assign tx_fire       = o_tx_tvalid && i_tx_tready;
  assign has_payload   = (op_q == 2'b11) && !err_q && !rty_q;

  // Payload byte is always the low byte: data_q shifts right as bytes leave.
  always_comb begin
    o_tx_tdata = 8'h00;
    case (state)
      S_HDR:   o_tx_tdata = {op_q, 4'b0000, err_q, rty_q};
      S_DATA:  o_tx_tdata = data_q[7:0];
      default: o_tx_tdata = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= 2'b00;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cres_fire) begin
            op_q   <= op_in;
            err_q  <= i_cres_bus_err;
            rty_q  <= i_cres_bus_rty;
            data_q <= DATA_W'(i_cres_hw_data);
            state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_fire) begin
            cnt   <= '0;
            state <= has_payload ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (tx_fire) begin
            data_q <= data_q >> 8;
            if (cnt == CNT_LAST) state <= S_IDLE;
            else                 cnt   <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbcon_tx.sv
// Self-checking bench for wbcon_tx: table vectors, hand-written corner
// sequences and a randomized stream scored against a frame-level encoder model.
module tb_wbcon_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cres_tvalid = 1'b0;
  logic        cres_tready;
  logic        op_null = 1'b0, op_sa = 1'b0, op_wr = 1'b0, op_rd = 1'b0;
  logic [31:0] hw_data = '0;
  logic        bus_err = 1'b0, bus_rty = 1'b0;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic [7:0]  tx_tdata;

  int vectors = 0;
  int miscompares = 0;
  int tready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int hs_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  wbcon_tx #(.WB_DATA_WIDTH(32)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_cres_tvalid         (cres_tvalid),
    .o_cres_tready         (cres_tready),
    .i_cres_op_null        (op_null),
    .i_cres_op_set_address (op_sa),
    .i_cres_op_write_word  (op_wr),
    .i_cres_op_read_word   (op_rd),
    .i_cres_hw_data        (hw_data),
    .i_cres_bus_err        (bus_err),
    .i_cres_bus_rty        (bus_rty),
    .o_tx_tvalid           (tx_tvalid),
    .i_tx_tready           (tx_tready),
    .o_tx_tdata            (tx_tdata)
  );

  typedef struct {
    logic        rd, wr, sa, nl, err, rty;
    logic [31:0] data;
    logic [7:0]  hdr;
    int          len;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: header from op priority and status, payload as little-endian bytes.
  function automatic void push_frame(input logic rd, wr, sa, input logic err, rty,
                                     input logic [31:0] d);
    int op;
    if (rd)      op = 3;
    else if (wr) op = 2;
    else if (sa) op = 1;
    else         op = 0;
    exp_q.push_back(8'(op * 64 + (err ? 2 : 0) + (rty ? 1 : 0)));
    if (op == 3 && !err && !rty)
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((d / (32'd1 << (8 * i))) % 256));
  endfunction

  always begin
    @(posedge clk);
    #2;
    case (tready_mode)
      0:       tx_tready = 1'b1;
      1:       tx_tready = 1'($urandom % 2);
      default: tx_tready = 1'b0;
    endcase
  end

  // Byte monitor: scoreboard every handshake and check tdata holds while stalled.
  logic       stalled = 1'b0;
  logic [7:0] stalled_data = 8'h00;
  always begin
    @(negedge clk);
    if (stalled) begin
      check("stall_valid_held", tx_tvalid, 1'b1);
      check("stall_data_held", tx_tdata, stalled_data);
    end
    stalled      = tx_tvalid && !tx_tready && !rst;
    stalled_data = tx_tdata;
    if (tx_tvalid && tx_tready && !rst) begin
      hs_cnt++;
      got_q.push_back(tx_tdata);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected_byte: got 0x%0h expected no byte at %0t", tx_tdata, $time);
      end else begin
        check("tx_byte", tx_tdata, exp_q.pop_front());
      end
    end
  end

  // Presents one result and holds it until accepted; returns at posedge+1 after the accept edge.
  task automatic send(input logic rd, wr, sa, nl, err, rty, input logic [31:0] d);
    bit accepted = 0;
    @(posedge clk);
    #1;
    op_rd = rd; op_wr = wr; op_sa = sa; op_null = nl;
    bus_err = err; bus_rty = rty; hw_data = d;
    cres_tvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (cres_tready) begin
        accepted = 1;
        break;
      end
    end
    if (accepted) begin
      check("accept_while_pending", exp_q.size(), 0);
      push_frame(rd, wr, sa, err, rty, d);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL cres_accept_timeout: got tready=0 expected tready=1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    cres_tvalid = 1'b0;
    {op_rd, op_wr, op_sa, op_null, bus_err, bus_rty} = '0;
    hw_data = $urandom;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cres_tready) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] e[5];
    e = '{b0, b1, b2, b3, b4};
    check({name, "_len"}, got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check(name, got_q[i], e[i]);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 32'hA1B2C3D4, 8'hC0, 5};
    tbl[1] = '{1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 8'hC2, 1};
    tbl[2] = '{1, 0, 0, 0, 0, 1, 32'h12345678, 8'hC1, 1};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 8'h80, 1};
    tbl[4] = '{0, 0, 1, 0, 0, 0, 32'h0000FFFF, 8'h40, 1};
    tbl[5] = '{0, 0, 0, 1, 0, 0, 32'hCAFEF00D, 8'h00, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 32'h87654321, 8'h00, 1};
    tbl[7] = '{1, 1, 0, 0, 0, 0, 32'h55667788, 8'hC0, 5};
    tbl[8] = '{1, 0, 0, 0, 1, 1, 32'h0BADCAFE, 8'hC3, 1};
    tbl[9] = '{0, 1, 1, 1, 1, 0, 32'h00000000, 8'h82, 1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx_tvalid", tx_tvalid, 1'b0);
    check("reset_tx_tdata", tx_tdata, 8'h00);
    check("reset_cres_tready", cres_tready, 1'b1);

    // Read success: header one cycle after accept, then four back-to-back bytes.
    got_q.delete();
    send(1, 0, 0, 0, 0, 0, 32'hA1B2C3D4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("read_busy_tvalid", tx_tvalid, 1'b1);
      check("read_busy_cres_tready", cres_tready, 1'b0);
    end
    @(negedge clk);
    check("read_done_tvalid", tx_tvalid, 1'b0);
    check("read_done_cres_tready", cres_tready, 1'b1);
    check_frame("read_frame", 8'hC0, 8'hD4, 8'hC3, 8'hB2, 8'hA1);

    foreach (tbl[i]) begin
      got_q.delete();
      send(tbl[i].rd, tbl[i].wr, tbl[i].sa, tbl[i].nl, tbl[i].err, tbl[i].rty, tbl[i].data);
      wait_drain();
      check("tbl_len", got_q.size(), tbl[i].len);
      if (got_q.size() > 0) check("tbl_hdr", got_q[0], tbl[i].hdr);
    end

    // Backpressure: random tx_tready must not drop, duplicate or reorder bytes.
    tready_mode = 1;
    got_q.delete();
    send(1, 0, 0, 0, 0, 0, 32'h11223344);
    wait_drain();
    check_frame("bp_frame", 8'hC0, 8'h44, 8'h33, 8'h22, 8'h11);
    for (int n = 0; n < 20; n++)
      send(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
           1'($urandom % 4 == 0), 1'($urandom % 4 == 0), $urandom);
    wait_drain();

    // Throughput: 100 mixed results presented back to back with tx_tready held high.
    tready_mode = 0;
    for (int n = 0; n < 100; n++)
      send(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
           1'($urandom % 5 == 0), 1'($urandom % 5 == 0), $urandom);
    wait_drain();

    // Reset after the second payload byte is taken abandons the frame.
    hs_cnt = 0;
    send(1, 0, 0, 0, 0, 0, 32'hA1B2C3D4);
    for (int k = 0; k < 50 && hs_cnt < 3; k++) @(negedge clk);
    check("rst_mid_handshakes", hs_cnt, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tready_mode = 2;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", tx_tvalid, 1'b0);
    check("rst_mid_tdata", tx_tdata, 8'h00);
    check("rst_mid_cres_tready", cres_tready, 1'b1);
    tready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", tx_tvalid, 1'b0);
    end
    got_q.delete();
    send(1, 0, 0, 0, 0, 0, 32'h00000001);
    wait_drain();
    check_frame("post_rst_frame", 8'hC0, 8'h01, 8'h00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
